alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_muldiv_iter.sv | 49 ++++
 rtl/alu_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared definitions for the sequential ALU: operation codes,
//                controller state type and flag bit positions.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    // Operation encoding on the 3-bit op port
    localparam logic [2:0] C_OP_ADD = 3'd0;
    localparam logic [2:0] C_OP_SUB = 3'd1;
    localparam logic [2:0] C_OP_CMP = 3'd2;
    localparam logic [2:0] C_OP_AND = 3'd3;
    localparam logic [2:0] C_OP_OR  = 3'd4;
    localparam logic [2:0] C_OP_XOR = 3'd5;
    localparam logic [2:0] C_OP_MUL = 3'd6;
    localparam logic [2:0] C_OP_DIV = 3'd7;

    // Controller states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bit positions inside the internal flag vector
    localparam int C_FLAG_CNT = 6;
    localparam int C_FLAG_N   = 5;
    localparam int C_FLAG_Z   = 4;
    localparam int C_FLAG_C   = 3;
    localparam int C_FLAG_V   = 2;
    localparam int C_FLAG_L   = 1;
    localparam int C_FLAG_DZ  = 0;

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_iter
//  Description : One combinational iteration of unsigned multiply (shift-add,
//                right shift) or restoring divide (left shift, trial
//                subtract) on the {acc, q} register pair.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_muldiv_iter #(
    parameter int WIDTH = 16
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    // Multiply: add the multiplicand when the current multiplier bit is set;
    // the extra bit keeps the carry that gets shifted back into acc.
    logic [WIDTH:0]   w_sum;
    // Divide: partial remainder shifted left by one with the next dividend bit.
    logic [WIDTH:0]   w_shl;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    assign w_sum  = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
    assign w_shl  = {i_acc, i_q[WIDTH-1]};
    assign w_fits = (w_shl >= {1'b0, i_opnd});
    // When the divisor fits, the difference is below the divisor, so the
    // truncated subtraction is exact.
    assign w_diff = w_shl[WIDTH-1:0] - i_opnd;

    // Select the multiply or divide step result
    always_comb begin
        o_acc = i_acc;
        o_q   = i_q;
        if (i_div) begin
            o_acc = w_fits ? w_diff : w_shl[WIDTH-1:0];
            o_q   = {i_q[WIDTH-2:0], w_fits};
        end else begin
            o_acc = w_sum[WIDTH:1];
            o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked ALU. ADD/SUB/CMP/logic complete on the sampling
//                edge; MUL/DIV iterate WIDTH cycles through alu_muldiv_iter.
//                Result and flags are registered and change only with done.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_l,
    output logic             flag_dz
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t                  r_state, w_state_nxt;
    logic [WIDTH-1:0]        r_acc, w_acc;
    logic [WIDTH-1:0]        r_q, w_q;
    logic [WIDTH-1:0]        r_opnd, w_opnd;
    logic                    r_div, w_div;
    logic [CNT_W-1:0]        r_cnt, w_cnt;
    logic                    r_done, w_done;
    logic [WIDTH-1:0]        r_result, w_result;
    logic [WIDTH-1:0]        r_result_hi, w_result_hi;
    logic [C_FLAG_CNT-1:0]   r_flags, w_flags;

    // Single-cycle arithmetic on the live operands
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_add_v;
    logic             w_sub_v;
    logic [WIDTH-1:0] w_it_acc;
    logic [WIDTH-1:0] w_it_q;

    assign w_add   = {1'b0, a} + {1'b0, b};
    // a + ~b + 1: the carry-out is the inverse of the unsigned borrow
    assign w_sub   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_add_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
    assign w_sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .i_div  (r_div),
        .i_acc  (r_acc),
        .i_q    (r_q),
        .i_opnd (r_opnd),
        .o_acc  (w_it_acc),
        .o_q    (w_it_q)
    );

    // Controller state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, iteration datapath and result/flag updates
    always_comb begin
        w_state_nxt = r_state;
        w_acc       = r_acc;
        w_q         = r_q;
        w_opnd      = r_opnd;
        w_div       = r_div;
        w_cnt       = r_cnt;
        w_done      = 1'b0;
        w_result    = r_result;
        w_result_hi = r_result_hi;
        w_flags     = r_flags;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_done  = 1'b1;
                    w_flags = '0;
                    case (op)
                        C_OP_ADD: begin
                            w_result           = w_add[WIDTH-1:0];
                            w_result_hi        = '0;
                            w_flags[C_FLAG_C]  = w_add[WIDTH];
                            w_flags[C_FLAG_V]  = w_add_v;
                            w_flags[C_FLAG_N]  = w_add[WIDTH-1];
                            w_flags[C_FLAG_Z]  = (w_add[WIDTH-1:0] == '0);
                        end
                        C_OP_SUB: begin
                            w_result           = w_sub[WIDTH-1:0];
                            w_result_hi        = '0;
                            w_flags[C_FLAG_C]  = ~w_sub[WIDTH];
                            w_flags[C_FLAG_V]  = w_sub_v;
                            w_flags[C_FLAG_N]  = w_sub[WIDTH-1] ^ w_sub_v;
                            w_flags[C_FLAG_Z]  = (w_sub[WIDTH-1:0] == '0);
                        end
                        C_OP_CMP: begin
                            // Result registers are left untouched by a compare
                            w_flags[C_FLAG_L]  = ~w_sub[WIDTH];
                            w_flags[C_FLAG_N]  = w_sub[WIDTH-1] ^ w_sub_v;
                            w_flags[C_FLAG_Z]  = (w_sub[WIDTH-1:0] == '0);
                        end
                        C_OP_AND: begin
                            w_result           = a & b;
                            w_result_hi        = '0;
                            w_flags[C_FLAG_Z]  = ((a & b) == '0);
                        end
                        C_OP_OR: begin
                            w_result           = a | b;
                            w_result_hi        = '0;
                            w_flags[C_FLAG_Z]  = ((a | b) == '0);
                        end
                        C_OP_XOR: begin
                            w_result           = a ^ b;
                            w_result_hi        = '0;
                            w_flags[C_FLAG_Z]  = ((a ^ b) == '0);
                        end
                        default: begin
                            if ((op == C_OP_DIV) && (b == '0)) begin
                                w_result           = '1;
                                w_result_hi        = a;
                                w_flags[C_FLAG_DZ] = 1'b1;
                            end else begin
                                // MUL runs the full iteration count even for
                                // a zero multiplier to keep latency uniform.
                                w_done      = 1'b0;
                                w_flags     = r_flags;
                                w_div       = (op == C_OP_DIV);
                                w_acc       = '0;
                                w_q         = (op == C_OP_DIV) ? a : b;
                                w_opnd      = (op == C_OP_DIV) ? b : a;
                                w_cnt       = '0;
                                w_state_nxt = ST_RUN;
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                w_acc = w_it_acc;
                w_q   = w_it_q;
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == C_LAST) begin
                    w_done      = 1'b1;
                    w_flags     = '0;
                    w_state_nxt = ST_IDLE;
                    if (r_div) begin
                        w_result          = w_it_q;
                        w_result_hi       = w_it_acc;
                        w_flags[C_FLAG_Z] = (w_it_q == '0);
                    end else begin
                        w_result          = w_it_q;
                        w_result_hi       = w_it_acc;
                        w_flags[C_FLAG_C] = (w_it_acc != '0);
                        w_flags[C_FLAG_Z] = ({w_it_acc, w_it_q} == '0);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc       <= '0;
            r_q         <= '0;
            r_opnd      <= '0;
            r_div       <= 1'b0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
        end else begin
            r_acc       <= w_acc;
            r_q         <= w_q;
            r_opnd      <= w_opnd;
            r_div       <= w_div;
            r_cnt       <= w_cnt;
            r_done      <= w_done;
            r_result    <= w_result;
            r_result_hi <= w_result_hi;
            r_flags     <= w_flags;
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign done      = r_done;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign flag_n    = r_flags[C_FLAG_N];
    assign flag_z    = r_flags[C_FLAG_Z];
    assign flag_c    = r_flags[C_FLAG_C];
    assign flag_v    = r_flags[C_FLAG_V];
    assign flag_l    = r_flags[C_FLAG_L];
    assign flag_dz   = r_flags[C_FLAG_DZ];

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq: directed scenarios followed
//                by random operations against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result, result_hi;
    logic         flag_n, flag_z, flag_c, flag_v, flag_l, flag_dz;

    int checks = 0;
    int errors = 0;

    // Reference model state: {n,z,c,v,l,dz}
    logic [W-1:0] m_res  = '0;
    logic [W-1:0] m_hi   = '0;
    logic [5:0]   m_flg  = '0;
    int           m_lat  = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_l    (flag_l),
        .flag_dz   (flag_dz)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] obs_flags();
        return {flag_n, flag_z, flag_c, flag_v, flag_l, flag_dz};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model computed from the operation definitions
    task automatic model(input int o, input int x, input int y);
        int sx, sy, t;
        longint p;
        logic n, z, c, v, l, dz;
        sx = (x >= 32768) ? x - 65536 : x;
        sy = (y >= 32768) ? y - 65536 : y;
        {n, z, c, v, l, dz} = '0;
        m_lat = 0;
        case (o)
            0: begin
                t = x + y;
                m_res = W'(t); m_hi = '0;
                c = (t >= 65536);
                v = ((sx + sy) > 32767) || ((sx + sy) < -32768);
                n = m_res[W-1];
                z = (m_res == 0);
            end
            1: begin
                m_res = W'(x - y); m_hi = '0;
                c = (x < y);
                v = ((sx - sy) > 32767) || ((sx - sy) < -32768);
                n = ((sx - sy) < 0);
                z = (x == y);
            end
            2: begin
                l = (x < y);
                n = ((sx - sy) < 0);
                z = (x == y);
            end
            3: begin m_res = W'(x & y); m_hi = '0; z = (m_res == 0); end
            4: begin m_res = W'(x | y); m_hi = '0; z = (m_res == 0); end
            5: begin m_res = W'(x ^ y); m_hi = '0; z = (m_res == 0); end
            6: begin
                p = longint'(x) * longint'(y);
                m_res = W'(p); m_hi = W'(p >> W);
                c = (m_hi != 0);
                z = (p == 0);
                m_lat = W;
            end
            default: begin
                if (y == 0) begin
                    m_res = '1; m_hi = W'(x); dz = 1'b1;
                end else begin
                    m_res = W'(x / y); m_hi = W'(x % y);
                    z = ((x / y) == 0);
                    m_lat = W;
                end
            end
        endcase
        m_flg = {n, z, c, v, l, dz};
    endtask

    // Issue one op, wait for done within a cycle budget, compare everything.
    // With poke set, a stray ADD start is pulsed while the op is in flight.
    task automatic run_op(input string tag, input int o, input int x, input int y, input bit poke);
        int lat;
        @(negedge clk);
        start = 1'b1; op = 3'(o); a = W'(x); b = W'(y);
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        model(o, x, y);
        check({tag, "_busy"}, 64'(busy), 64'(m_lat > 0));
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            start = poke && (lat == 5);
        end
        start = 1'b0;
        check({tag, "_lat"},   64'(lat),         64'(m_lat));
        check({tag, "_res"},   64'(result),      64'(m_res));
        check({tag, "_hi"},    64'(result_hi),   64'(m_hi));
        check({tag, "_flags"}, 64'(obs_flags()), 64'(m_flg));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        bit saw_done;
        int lat;
        int o, x, y;

        resetn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        #12;
        check("rst_busy",  64'(busy),        64'd0);
        check("rst_done",  64'(done),        64'd0);
        check("rst_res",   64'(result),      64'd0);
        check("rst_hi",    64'(result_hi),   64'd0);
        check("rst_flags", 64'(obs_flags()), 64'd0);
        @(negedge clk); resetn = 1'b1;

        // Directed scenarios
        run_op("add_ovf", 0, 'h7FFF, 'h0001, 1'b0);
        run_op("sub_neg", 1, 'h0003, 'h0005, 1'b0);
        run_op("cmp_lt",  2, 'h0003, 'h0005, 1'b0);
        run_op("mul",     6, 'h1234, 'h0100, 1'b1);
        run_op("div",     7, 100, 7, 1'b0);
        run_op("div0",    7, 'h00AB, 0, 1'b0);
        run_op("cmp_eq",  2, 'h8000, 'h8000, 1'b0);
        run_op("sub_ovf", 1, 'h8000, 'h0001, 1'b0);
        run_op("and_z",   3, 'hF0F0, 'h0F0F, 1'b0);

        // Reset during RUN cycle 5 of a multiply
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 16'h00FF; b = 16'h0F0F;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("abort_busy",  64'(busy),        64'd0);
        check("abort_done",  64'(done),        64'd0);
        check("abort_res",   64'(result),      64'd0);
        check("abort_hi",    64'(result_hi),   64'd0);
        check("abort_flags", 64'(obs_flags()), 64'd0);
        m_res = '0; m_hi = '0; m_flg = '0;
        @(negedge clk); resetn = 1'b1;
        saw_done = 1'b0;
        repeat (24) begin
            @(posedge clk); #1;
            saw_done |= done;
        end
        check("abort_nodone", 64'(saw_done), 64'd0);

        // Back-to-back: ADD issued in the done cycle of a DIV
        @(negedge clk);
        start = 1'b1; op = 3'd7; a = 16'd100; b = 16'd7;
        @(posedge clk); #1; start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("b2b_div_lat", 64'(lat),       64'(W));
        check("b2b_div_res", 64'(result),    64'd14);
        check("b2b_div_hi",  64'(result_hi), 64'd2);
        start = 1'b1; op = 3'd0; a = 16'h1111; b = 16'h2222;
        @(posedge clk); #1; start = 1'b0;
        model(0, 'h1111, 'h2222);
        check("b2b_add_done",  64'(done),        64'd1);
        check("b2b_add_res",   64'(result),      64'(m_res));
        check("b2b_add_flags", 64'(obs_flags()), 64'(m_flg));
        @(posedge clk); #1;
        check("b2b_add_pulse", 64'(done), 64'd0);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            o = int'($urandom_range(0, 7));
            x = int'($urandom_range(0, 65535));
            y = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) y = x;
            if ($urandom_range(0, 3) == 0) y = int'($urandom_range(0, 15));
            if (o == 6 && y == 0) y = 1;
            if (o == 7 && $urandom_range(0, 5) == 0) y = 0;
            run_op($sformatf("rnd%0d_op%0d", i, o), o, x, y, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
